// File: rtl/playback_scheduler.sv
// Paces ring-buffer playback: tracks occupancy from write strobes, waits for a
// prefill level, then issues one read trigger per PERIOD and flags under/overrun.
module playback_scheduler #(
    parameter int ENTRIES = 4400,
    parameter int PERIOD  = 2304,
    parameter int PREFILL = 2048,
    parameter int FILL_W  = $clog2(ENTRIES + 1)
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              enable_in,
    input  logic              write_valid_in,
    output logic              write_accept_out,
    output logic              read_trigger_out,
    output logic [FILL_W-1:0] fill_out,
    output logic              playing_out,
    output logic              underrun_out,
    output logic              overrun_out,
    output logic [15:0]       underrun_count_out
);

    localparam int TICK_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [FILL_W-1:0] FULL_LVL    = FILL_W'(ENTRIES);
    localparam logic [FILL_W-1:0] PREFILL_LVL = FILL_W'(PREFILL);
    localparam logic [TICK_W-1:0] LAST_TICK   = TICK_W'(PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILLING = 2'd1,
        PLAYING = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [15:0]       ucnt_q, ucnt_d;
    logic              rd_q, rd_d;
    logic              under_q, under_d;
    logic              over_q, over_d;
    logic              play_q, play_d;
    logic              accept;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // A write and a read in the same edge cancel out.
    function automatic logic [FILL_W-1:0] fill_next(input logic [FILL_W-1:0] f,
                                                    input logic inc,
                                                    input logic dec);
        logic [FILL_W-1:0] r;
        case ({inc, dec})
            2'b10:   r = f + FILL_W'(1);
            2'b01:   r = f - FILL_W'(1);
            default: r = f;
        endcase
        return r;
    endfunction

    assign accept = write_valid_in && (fill_q < FULL_LVL);

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        ucnt_d  = ucnt_q;
        rd_d    = 1'b0;
        under_d = 1'b0;
        over_d  = write_valid_in && !accept;
        if (!enable_in) begin
            state_d = IDLE;
            tick_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FILLING;
                    tick_d  = '0;
                end
                FILLING: begin
                    if (fill_q >= PREFILL_LVL) begin
                        state_d = PLAYING;
                        tick_d  = '0;
                    end
                end
                PLAYING: begin
                    if (tick_q == LAST_TICK) begin
                        tick_d = '0;
                        if (fill_q != '0) begin
                            rd_d = 1'b1;
                        end else begin
                            under_d = 1'b1;
                            ucnt_d  = sat_inc16(ucnt_q);
                            state_d = FILLING;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    tick_d  = '0;
                end
            endcase
        end
        fill_d = fill_next(fill_q, accept, rd_d);
        play_d = (state_d == PLAYING);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            tick_q  <= '0;
            fill_q  <= '0;
            ucnt_q  <= '0;
            rd_q    <= 1'b0;
            under_q <= 1'b0;
            over_q  <= 1'b0;
            play_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            fill_q  <= fill_d;
            ucnt_q  <= ucnt_d;
            rd_q    <= rd_d;
            under_q <= under_d;
            over_q  <= over_d;
            play_q  <= play_d;
        end
    end

    assign write_accept_out   = accept;
    assign read_trigger_out   = rd_q;
    assign fill_out           = fill_q;
    assign playing_out        = play_q;
    assign underrun_out       = under_q;
    assign overrun_out        = over_q;
    assign underrun_count_out = ucnt_q;

endmodule

// File: tb/tb_playback_scheduler.sv
// Bench for playback_scheduler: fixed vector table, hand sequences for
// multi-cycle corners, then random traffic against a queue-based model.
module tb_playback_scheduler;

    localparam int ENTRIES = 8;
    localparam int PERIOD  = 5;
    localparam int PREFILL = 4;
    localparam int FILL_W  = $clog2(ENTRIES + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              wv = 1'b0;
    logic              acc;
    logic              rd;
    logic [FILL_W-1:0] fill;
    logic              play;
    logic              un;
    logic              ov;
    logic [15:0]       ucnt;

    playback_scheduler #(
        .ENTRIES(ENTRIES),
        .PERIOD (PERIOD),
        .PREFILL(PREFILL)
    ) dut (
        .clk_in            (clk),
        .rst_n_in          (rst_n),
        .enable_in         (en),
        .write_valid_in    (wv),
        .write_accept_out  (acc),
        .read_trigger_out  (rd),
        .fill_out          (fill),
        .playing_out       (play),
        .underrun_out      (un),
        .overrun_out       (ov),
        .underrun_count_out(ucnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: occupancy is a queue of sample ids, playback slots are
    // absolute edge numbers spaced PERIOD apart from the start of playback.
    int      m_mode;      // 0 idle, 1 filling, 2 playing
    longint  cyc = 0;
    longint  next_slot = 0;
    int      m_q[$];
    int      m_ucnt = 0;
    int      sample_id = 0;
    bit      m_rd, m_un, m_ov, m_play;
    bit      seen_reset = 0;
    logic    last_acc;

    function automatic void model_edge(bit r, bit e, bit w);
        bit a;
        cyc++;
        m_rd = 0; m_un = 0; m_ov = 0;
        if (!r) begin
            m_mode = 0; m_q.delete(); m_ucnt = 0; m_play = 0;
            return;
        end
        a    = w && (m_q.size() < ENTRIES);
        m_ov = w && !a;
        if (!e) m_mode = 0;
        else if (m_mode == 0) m_mode = 1;
        else if (m_mode == 1) begin
            if (m_q.size() >= PREFILL) begin
                m_mode = 2;
                next_slot = cyc + PERIOD;
            end
        end else if (cyc == next_slot) begin
            next_slot = cyc + PERIOD;
            if (m_q.size() > 0) m_rd = 1;
            else begin
                m_un = 1;
                if (m_ucnt < 65535) m_ucnt++;
                m_mode = 1;
            end
        end
        if (m_rd) void'(m_q.pop_front());
        if (a) m_q.push_back(sample_id++);
        m_play = (m_mode == 2);
    endfunction

    // One cycle: drive at negedge, check combinational accept, model the edge,
    // compare registered outputs at the following negedge.
    task automatic step(input bit r, input bit e, input bit w);
        rst_n = r; en = e; wv = w;
        #1;
        last_acc = acc;
        if (seen_reset) chk("mdl accept", last_acc, 32'(w && (m_q.size() < ENTRIES)));
        @(posedge clk);
        model_edge(r, e, w);
        if (!r) seen_reset = 1;
        @(negedge clk);
        if (seen_reset) begin
            chk("mdl fill", fill, m_q.size());
            chk("mdl playing", play, m_play);
            chk("mdl read_trigger", rd, m_rd);
            chk("mdl underrun", un, m_un);
            chk("mdl overrun", ov, m_ov);
            chk("mdl underrun_count", ucnt, m_ucnt);
        end
    endtask

    typedef struct {
        bit r, e, w;
        int acc;   // -1 = not checked
        int fill;
        bit play, rd, un, ov;
        int ucnt;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(bit r, bit e, bit w, int a, int f,
                                bit p, bit t, bit u, bit o, int c);
        vec_t v;
        v.r = r; v.e = e; v.w = w; v.acc = a; v.fill = f;
        v.play = p; v.rd = t; v.un = u; v.ov = o; v.ucnt = c;
        tbl.push_back(v);
    endfunction

    int n;
    bit got;
    int wp;
    bit rr, re, rw;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset held with writes pending
        add(0,0,1,-1,0,0,0,0,0,0);
        add(0,0,1, 1,0,0,0,0,0,0);
        add(0,0,1, 1,0,0,0,0,0,0);
        // prefill: four writes, playing rises the edge after fill reaches 4
        for (int k = 0; k < 4; k++) add(1,1,1,1,k+1,0,0,0,0,0);
        add(1,1,0,0,4,1,0,0,0,0);
        // drain 4 -> 0, one trigger every PERIOD
        for (int s = 0; s < 4; s++) begin
            for (int j = 0; j < 4; j++) add(1,1,0,0,4-s,1,0,0,0,0);
            add(1,1,0,0,3-s,1,1,0,0,0);
        end
        // empty slot underruns and drops back to filling
        for (int j = 0; j < 4; j++) add(1,1,0,0,0,1,0,0,0,0);
        add(1,1,0,0,0,0,0,1,0,1);
        add(1,1,0,0,0,0,0,0,0,1);
        // disabled writes saturate at ENTRIES, ninth is rejected
        for (int k = 0; k < 8; k++) add(1,0,1,1,k+1,0,0,0,0,1);
        add(1,0,1,0,8,0,0,0,1,1);
        add(1,0,0,0,8,0,0,0,0,1);
        // start playing, drop enable at tick 2, then reset
        add(1,1,0,0,8,0,0,0,0,1);
        add(1,1,0,0,8,1,0,0,0,1);
        add(1,1,0,0,8,1,0,0,0,1);
        add(1,1,0,0,8,1,0,0,0,1);
        add(1,0,0,0,8,0,0,0,0,1);
        for (int j = 0; j < 6; j++) add(1,0,0,0,8,0,0,0,0,1);
        add(0,0,0,0,0,0,0,0,0,0);

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].e, tbl[i].w);
            if (tbl[i].acc >= 0) chk($sformatf("row%0d accept", i), last_acc, tbl[i].acc);
            chk($sformatf("row%0d fill", i), fill, tbl[i].fill);
            chk($sformatf("row%0d playing", i), play, tbl[i].play);
            chk($sformatf("row%0d read_trigger", i), rd, tbl[i].rd);
            chk($sformatf("row%0d underrun", i), un, tbl[i].un);
            chk($sformatf("row%0d overrun", i), ov, tbl[i].ov);
            chk($sformatf("row%0d underrun_count", i), ucnt, tbl[i].ucnt);
        end

        // first-trigger latency, then a write coinciding with a trigger
        for (int k = 0; k < 4; k++) step(1,1,1);
        step(1,1,0);
        chk("seqA playing", play, 1);
        n = 0; got = 0;
        while (!got && n < 20) begin
            step(1,1,0);
            n++;
            got = rd;
        end
        chk("seqA latency", n, PERIOD);
        chk("seqA fill after trigger", fill, 3);
        for (int k = 0; k < 4; k++) step(1,1,0);
        step(1,1,1);
        chk("seqA simultaneous trigger", rd, 1);
        chk("seqA simultaneous fill", fill, 3);

        // full buffer: a same-edge read does not credit the rejected write
        step(0,0,0);
        n = 0; got = 0;
        while (!got && n < 30) begin
            step(1,1,1);
            n++;
            got = rd;
        end
        chk("seqB trigger seen", got, 1);
        chk("seqB overrun with read", ov, 1);
        chk("seqB fill", fill, 7);

        // random traffic with phase-varying write density
        wp = 25;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                case ($urandom_range(0, 4))
                    0: wp = 5;
                    1: wp = 15;
                    2: wp = 25;
                    3: wp = 60;
                    default: wp = 95;
                endcase
            end
            rr = ($urandom_range(0, 499) != 0);
            re = ($urandom_range(0, 31) != 0);
            rw = ($urandom_range(0, 99) < wp);
            step(rr, re, rw);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
